// File: rtl/ets_ctrl_pkg.sv
// Shared definitions for the ETS phase-sweep controller: FSM state
// encoding and default parameter values.
package ets_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_SAMPLE    = 3'd2,
      ST_EMIT      = 3'd3,
      ST_PS_REQ    = 3'd4,
      ST_PS_WAIT   = 3'd5,
      ST_SETTLE    = 3'd6,
      ST_FINISH    = 3'd7
   } sweep_state_t;

   localparam int DEF_STEP_W     = 10;
   localparam int DEF_CNT_W      = 16;
   localparam int DEF_SETTLE_CYC = 16;
   localparam int DEF_PS_TIMEOUT = 1023;

   // Width of the shared cycle counter used for sampling, timeout and settle.
   localparam int TMR_W = 32;

endpackage

// File: rtl/ets_hit_counter.sv
// Saturating hit accumulator: counts cycles where hit=1 while enabled.
// Clear has priority over counting; the count sticks at all-ones.
module ets_hit_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         hit,
   output logic [W-1:0] count
);

   // Accumulate hits, saturating at the maximum representable value.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && hit && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/ets_phase_sweep_ctrl.sv
// Equivalent-time-sampling phase sweep controller. Steps an MMCM through
// cfg_steps phase points, counts comparator hits at each point and streams
// one (step, hits) result per point.
module ets_phase_sweep_ctrl
   import ets_ctrl_pkg::*;
#(
   parameter int STEP_W     = DEF_STEP_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int PS_TIMEOUT = DEF_PS_TIMEOUT
) (
   input  logic              free_run_clk,
   input  logic              free_run_rst,
   input  logic              start,
   input  logic              abort,
   input  logic [STEP_W-1:0] cfg_steps,
   input  logic [CNT_W-1:0]  cfg_samples,
   input  logic              cfg_dir,
   input  logic              locked,
   input  logic              cmp_data,
   output logic              ps_en,
   output logic              ps_incdec,
   input  logic              ps_done,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [STEP_W-1:0] res_step,
   output logic [CNT_W-1:0]  res_hits,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(PS_TIMEOUT - 1);

   sweep_state_t      state;
   logic [STEP_W-1:0] last_step;
   logic [CNT_W-1:0]  samples_cfg;
   logic [STEP_W-1:0] index;
   logic [TMR_W-1:0]  cyc;
   logic [TMR_W-1:0]  samples_last;
   logic [CNT_W-1:0]  acc;
   logic              acc_clr;
   logic              acc_en;

   assign samples_last = TMR_W'(samples_cfg) - TMR_W'(1);

   // Index and accumulator are flops, so the result fields are registered.
   assign res_step = index;
   assign res_hits = acc;

   // Accumulator control: clear on a new sweep or a new phase point,
   // count only while sampling.
   always_comb begin
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      if ((state == ST_IDLE && start) || (state == ST_PS_WAIT && ps_done)) begin
         acc_clr = 1'b1;
      end else begin
         acc_clr = 1'b0;
      end
      if (state == ST_SAMPLE) begin
         acc_en = 1'b1;
      end else begin
         acc_en = 1'b0;
      end
   end

   ets_hit_counter #(
      .W (CNT_W)
   ) u_hit_counter (
      .clk   (free_run_clk),
      .rst   (free_run_rst),
      .clr   (acc_clr),
      .en    (acc_en),
      .hit   (cmp_data),
      .count (acc)
   );

   // Sweep sequencer with registered handshake and status outputs.
   always_ff @(posedge free_run_clk) begin
      if (free_run_rst) begin
         state       <= ST_IDLE;
         last_step   <= '0;
         samples_cfg <= '0;
         index       <= '0;
         cyc         <= '0;
         ps_en       <= 1'b0;
         ps_incdec   <= 1'b0;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  // Zero-valued config fields mean "one".
                  last_step   <= (cfg_steps == '0) ? '0 : cfg_steps - STEP_W'(1);
                  samples_cfg <= (cfg_samples == '0) ? CNT_W'(1) : cfg_samples;
                  ps_incdec   <= cfg_dir;
                  index       <= '0;
                  err         <= 1'b0;
                  busy        <= 1'b1;
                  state       <= ST_WAIT_LOCK;
               end
            end
            ST_WAIT_LOCK: begin
               if (abort) begin
                  done  <= 1'b1;
                  state <= ST_FINISH;
               end else if (locked) begin
                  cyc   <= '0;
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (!locked) begin
                  // Lock lost: the partial point is thrown away.
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= ST_FINISH;
               end else if (cyc == samples_last) begin
                  res_valid <= 1'b1;
                  state     <= ST_EMIT;
               end else begin
                  cyc <= cyc + TMR_W'(1);
               end
            end
            ST_EMIT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if ((index == last_step) || abort) begin
                     done  <= 1'b1;
                     state <= ST_FINISH;
                  end else begin
                     ps_en <= 1'b1;
                     state <= ST_PS_REQ;
                  end
               end
            end
            ST_PS_REQ: begin
               ps_en <= 1'b0;
               cyc   <= '0;
               state <= ST_PS_WAIT;
            end
            ST_PS_WAIT: begin
               if (ps_done) begin
                  index <= index + STEP_W'(1);
                  cyc   <= '0;
                  state <= ST_SETTLE;
               end else if (cyc == TIMEOUT_LAST) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= ST_FINISH;
               end else begin
                  cyc <= cyc + TMR_W'(1);
               end
            end
            ST_SETTLE: begin
               if (cyc == SETTLE_LAST) begin
                  cyc   <= '0;
                  state <= locked ? ST_SAMPLE : ST_WAIT_LOCK;
               end else begin
                  cyc <= cyc + TMR_W'(1);
               end
            end
            ST_FINISH: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               ps_incdec <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               ps_en     <= 1'b0;
               res_valid <= 1'b0;
               done      <= 1'b0;
               busy      <= 1'b0;
               ps_incdec <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ets_phase_sweep_ctrl.sv
// Self-checking bench for ets_phase_sweep_ctrl: directed sweeps, a
// per-cycle output monitor and a result scoreboard.
module tb_ets_phase_sweep_ctrl;

   localparam int STEP_W  = 10;
   localparam int CNT_W   = 16;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 30;

   logic              free_run_clk;
   logic              free_run_rst;
   logic              start;
   logic              abort;
   logic [STEP_W-1:0] cfg_steps;
   logic [CNT_W-1:0]  cfg_samples;
   logic              cfg_dir;
   logic              locked;
   logic              cmp_data;
   logic              ps_en;
   logic              ps_incdec;
   logic              ps_done;
   logic              res_valid;
   logic              res_ready;
   logic [STEP_W-1:0] res_step;
   logic [CNT_W-1:0]  res_hits;
   logic              busy;
   logic              done;
   logic              err;

   ets_phase_sweep_ctrl #(
      .STEP_W     (STEP_W),
      .CNT_W      (CNT_W),
      .SETTLE_CYC (SETTLE),
      .PS_TIMEOUT (TIMEOUT)
   ) dut (
      .free_run_clk (free_run_clk),
      .free_run_rst (free_run_rst),
      .start        (start),
      .abort        (abort),
      .cfg_steps    (cfg_steps),
      .cfg_samples  (cfg_samples),
      .cfg_dir      (cfg_dir),
      .locked       (locked),
      .cmp_data     (cmp_data),
      .ps_en        (ps_en),
      .ps_incdec    (ps_incdec),
      .ps_done      (ps_done),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_step     (res_step),
      .res_hits     (res_hits),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   initial begin
      free_run_clk = 1'b0;
      forever #5 free_run_clk = ~free_run_clk;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // Hits the spec predicts for n consecutive samples of a stimulus pattern.
   function automatic int exp_hits(input int pat, input int n);
      int ne;
      ne = (n == 0) ? 1 : n;
      if (pat == 0) return ne;        // always 1
      else if (pat == 1) return ne / 2; // alternating, even n
      else return ne / 4;              // one in four, n multiple of 4
   endfunction

   // Bench state shared by monitor and stimulus.
   bit mon_on   = 1'b0;
   bit ps_resp  = 1'b1;
   bit bp_mode  = 1'b0;
   int pattern  = 0;
   int cur_dir  = 0;
   int gcyc     = 0;
   int cyc_no   = 0;
   int ps_cnt   = 0;
   int done_cnt = 0;
   int psd_cnt  = 0;
   int stall_cnt = 0;
   int last_ps_cyc = 0;
   int done_cyc = 0;
   int err_at_done = 0;
   int got_step[$];
   int got_hits[$];
   logic prev_ps_en = 1'b0;
   logic prev_done  = 1'b0;
   logic prev_stall = 1'b0;
   int   prev_step  = 0;
   int   prev_hits  = 0;

   // Comparator stimulus generator.
   initial begin
      cmp_data = 1'b0;
      forever begin
         @(posedge free_run_clk);
         #1;
         gcyc++;
         if (pattern == 0) cmp_data = 1'b1;
         else if (pattern == 1) cmp_data = gcyc[0];
         else cmp_data = ((gcyc % 4) == 0);
      end
   end

   // Result-ready driver: optional 20-cycle back-pressure on the first result.
   initial begin
      res_ready = 1'b1;
      forever begin
         @(posedge free_run_clk);
         #1;
         res_ready = bp_mode ? (stall_cnt >= 20) : 1'b1;
      end
   end

   // MMCM model: ps_done five cycles after each ps_en.
   initial begin
      ps_done = 1'b0;
      forever begin
         @(negedge free_run_clk);
         if (ps_en && ps_resp && mon_on) begin
            repeat (5) @(posedge free_run_clk);
            #1 ps_done = 1'b1;
            psd_cnt++;
            @(posedge free_run_clk);
            #1 ps_done = 1'b0;
         end
      end
   end

   // Per-cycle monitor: protocol rules and result capture.
   always @(negedge free_run_clk) begin
      if (mon_on) begin
         cyc_no++;
         if (busy) chk("incdec_busy", 32'(ps_incdec), 32'(cur_dir));
         else      chk("incdec_idle", 32'(ps_incdec), 32'd0);
         if (ps_en) begin
            ps_cnt++;
            last_ps_cyc = cyc_no;
            chk("ps_en_single", 32'(prev_ps_en), 32'd0);
            chk("ps_en_during_valid", 32'(res_valid), 32'd0);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc_no;
            err_at_done = int'(err);
            chk("done_single", 32'(prev_done), 32'd0);
         end
         if (prev_stall) begin
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_step", 32'(res_step), 32'(prev_step));
            chk("hold_hits", 32'(res_hits), 32'(prev_hits));
         end
         if (res_valid && res_ready) begin
            got_step.push_back(int'(res_step));
            got_hits.push_back(int'(res_hits));
         end
         if (res_valid && !res_ready) stall_cnt++;
         prev_ps_en = ps_en;
         prev_done  = done;
         prev_stall = res_valid && !res_ready;
         prev_step  = int'(res_step);
         prev_hits  = int'(res_hits);
      end
   end

   // One sweep: program, start, optional mid-sweep poke, then score.
   task automatic run_sweep(input string nm, input int steps, input int samples,
                            input int dir, input int pat, input int exp_n,
                            input int exp_ps, input int exp_err, input int poke);
      int det;
      bit finished;
      det = -1;
      finished = 1'b0;
      cfg_steps   = STEP_W'(steps);
      cfg_samples = CNT_W'(samples);
      cfg_dir     = dir[0];
      pattern     = pat;
      got_step.delete();
      got_hits.delete();
      ps_cnt = 0; done_cnt = 0; psd_cnt = 0;
      @(posedge free_run_clk);
      #1 start = 1'b1;
      cur_dir = dir;
      @(posedge free_run_clk);
      #1 start = 1'b0;
      @(negedge free_run_clk);
      chk({nm, "_err_clr"}, 32'(err), 32'd0);
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      for (int it = 0; it < 3000; it++) begin
         @(posedge free_run_clk);
         #2;
         if (poke == 1 && it == 30) begin
            start = 1'b1; cfg_steps = STEP_W'(7); cfg_samples = CNT_W'(2); cfg_dir = ~dir[0];
         end
         if (poke == 1 && it == 31) start = 1'b0;
         if (poke == 2 && got_step.size() >= 1) abort = 1'b1;
         if (poke == 3 && it == 5) ps_done = 1'b1;
         if (poke == 3 && it == 6) ps_done = 1'b0;
         if (poke == 4 && det < 0 && psd_cnt == 2) det = it;
         if (poke == 4 && det >= 0 && it == det + 8) locked = 1'b0;
         if (poke == 5 && det < 0 && psd_cnt == 1) det = it;
         if (poke == 5 && det >= 0 && it == det + 2) locked = 1'b0;
         if (poke == 5 && det >= 0 && it == det + 12) locked = 1'b1;
         if (done_cnt > 0) begin
            finished = 1'b1;
            break;
         end
      end
      abort  = 1'b0;
      locked = 1'b1;
      if (!finished) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
      @(negedge free_run_clk);
      chk({nm, "_idle"}, 32'(busy), 32'd0);
      chk({nm, "_n_results"}, 32'(got_step.size()), 32'(exp_n));
      for (int i = 0; i < got_step.size() && i < exp_n; i++) begin
         chk({nm, "_step"}, 32'(got_step[i]), 32'(i));
         chk({nm, "_hits"}, 32'(got_hits[i]), 32'(exp_hits(pat, samples)));
      end
      chk({nm, "_ps_en_count"}, 32'(ps_cnt), 32'(exp_ps));
      chk({nm, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({nm, "_err"}, 32'(err_at_done), 32'(exp_err));
   endtask

   initial begin
      free_run_rst = 1'b1;
      start = 1'b0; abort = 1'b0; locked = 1'b1;
      cfg_steps = '0; cfg_samples = '0; cfg_dir = 1'b0;
      repeat (3) @(posedge free_run_clk);
      @(negedge free_run_clk);
      chk("rst_ps_en", 32'(ps_en), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_incdec", 32'(ps_incdec), 32'd0);
      chk("rst_step", 32'(res_step), 32'd0);
      chk("rst_hits", 32'(res_hits), 32'd0);
      @(posedge free_run_clk);
      #1 free_run_rst = 1'b0;
      mon_on = 1'b1;

      // Basic sweep with a stray ps_done during sampling.
      run_sweep("t1", 4, 8, 1, 0, 4, 3, 0, 3);
      chk("t1_hits_literal", 32'(got_hits[3]), 32'd8);
      // Alternating comparator, dir=0, start/cfg changes mid-sweep ignored.
      run_sweep("t2", 3, 16, 0, 1, 3, 2, 0, 1);
      chk("t2_hits_literal", 32'(got_hits[0]), 32'd8);
      // Back-pressure on the first result.
      bp_mode = 1'b1;
      stall_cnt = 0;
      run_sweep("t3", 2, 4, 1, 0, 2, 1, 0, 0);
      chk("t3_stall_cycles", 32'(stall_cnt), 32'd20);
      bp_mode = 1'b0;
      // Phase shift never completes.
      ps_resp = 1'b0;
      run_sweep("t4", 3, 2, 1, 0, 1, 1, 1, 0);
      chk("t4_timeout_latency", 32'(done_cyc - last_ps_cyc), 32'd31);
      ps_resp = 1'b1;
      // Lock lost while sampling step 2, then a fresh sweep clears err.
      run_sweep("t5", 4, 8, 1, 0, 2, 2, 1, 4);
      run_sweep("t5b", 1, 4, 0, 0, 1, 0, 0, 0);
      // Zero config values behave as one.
      run_sweep("t7", 0, 0, 1, 0, 1, 0, 0, 0);
      // Abort while waiting for lock.
      abort = 1'b1;
      run_sweep("t8", 4, 8, 1, 0, 0, 0, 0, 0);
      // Lock lost during settle: re-acquire then continue.
      run_sweep("t9", 2, 12, 0, 2, 2, 1, 0, 5);
      // Abort after the first result completes the current point only.
      run_sweep("t10", 4, 4, 1, 0, 2, 1, 0, 2);

      // Reset while waiting for ps_done.
      ps_resp = 1'b0;
      cfg_steps = STEP_W'(3); cfg_samples = CNT_W'(2); cfg_dir = 1'b1;
      pattern = 0; ps_cnt = 0; done_cnt = 0;
      @(posedge free_run_clk);
      #1 start = 1'b1;
      cur_dir = 1;
      @(posedge free_run_clk);
      #1 start = 1'b0;
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 200; i++) begin
            @(posedge free_run_clk);
            if (ps_cnt > 0) begin
               seen = 1'b1;
               break;
            end
         end
         chk("t6_ps_en_seen", 32'(seen), 32'd1);
      end
      repeat (3) @(posedge free_run_clk);
      #1 free_run_rst = 1'b1;
      @(posedge free_run_clk);
      #1 free_run_rst = 1'b0;
      @(negedge free_run_clk);
      chk("t6_ps_en", 32'(ps_en), 32'd0);
      chk("t6_res_valid", 32'(res_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      chk("t6_incdec", 32'(ps_incdec), 32'd0);
      repeat (10) @(posedge free_run_clk);
      @(negedge free_run_clk);
      chk("t6_no_done", 32'(done_cnt), 32'd0);
      chk("t6_still_idle", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
